// File: rtl/sched_noc_pkg.sv
// sched_noc_pkg -- shared definitions for the NoC scheduler with reorder buffer.
//
// Purpose:
//   Flit layout helpers (field offsets and total width), a minimum-one-bit
//   clog2 helper, and a flit struct typedef for the default configuration.
//   Flit layout, LSB first: x, y, tag, payload.
//
// Optional feature macro used by the importing files: SCHED_DUP_CHECK_EN.
package sched_noc_pkg;

  // A 1-wide mesh dimension still gets one (always-zero) coordinate bit so
  // that no flit field collapses to zero width.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

  function automatic int flit_x_lsb();
    return 0;
  endfunction

  function automatic int flit_y_lsb(input int xw);
    return xw;
  endfunction

  function automatic int flit_tag_lsb(input int xw, input int yw);
    return xw + yw;
  endfunction

  function automatic int flit_data_lsb(input int xw, input int yw, input int tag_w);
    return xw + yw + tag_w;
  endfunction

  function automatic int flit_width(input int xw, input int yw, input int tag_w,
                                    input int data_w);
    return xw + yw + tag_w + data_w;
  endfunction

  // Flit struct for the default build (4x4 mesh, 256-bit payload, 5-bit tag).
  localparam int DEF_DATA_W = 256;
  localparam int DEF_TAG_W  = 5;
  localparam int DEF_XW     = 2;
  localparam int DEF_YW     = 2;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] payload;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_YW-1:0]     y;
    logic [DEF_XW-1:0]     x;
  } flit_t;

endpackage

// File: rtl/sched_rob.sv
// sched_rob -- reorder buffer: slot storage, per-slot valid bits, read pointer
// and the in-order release handshake toward the host.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_en_i           returned flit valid (write slot wr_tag_i)
//   wr_tag_i          slot index of the returned flit
//   wr_data_i         returned payload
//   ready_i           host accepts the current result
//   valid_o, data_o   in-order result to the host (registered)
//   release_o         pulse: slot rd_ptr is being released this cycle
//   dup_o             (SCHED_DUP_CHECK_EN only) write hits an already-valid slot
module sched_rob
  import sched_noc_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              release_o
`ifdef SCHED_DUP_CHECK_EN
  ,
  output logic              dup_o
`endif
);

  localparam int DEPTH = 1 << TAG_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  slot_vld_q;
  logic [DEPTH-1:0]  slot_vld_d;
  logic [TAG_W-1:0]  rd_ptr_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              rel;

  assign rel       = slot_vld_q[rd_ptr_q] && (!valid_q || ready_i);
  assign release_o = rel;
  assign valid_o   = valid_q;
  assign data_o    = data_q;

`ifdef SCHED_DUP_CHECK_EN
  assign dup_o = wr_en_i && slot_vld_q[wr_tag_i];
`endif

  // Payload storage: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_tag_i] <= wr_data_i;
  end

  // A write to the slot being released re-arms it: set wins over clear.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_vld_d[gi] = (wr_en_i && (wr_tag_i == TAG_W'(gi))) ||
                            (slot_vld_q[gi] && !(rel && (rd_ptr_q == TAG_W'(gi))));
  end

  // The release reads the pre-write contents of the slot (registered read).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld_q <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      if (rel) begin
        data_q   <= mem_q[rd_ptr_q];
        valid_q  <= 1'b1;
        rd_ptr_q <= rd_ptr_q + TAG_W'(1);
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sched_noc_rob.sv
// sched_noc_rob -- scatters host payloads over a mesh NoC in raster order and
// returns the results to the host strictly in issue (tag) order.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_valid_pci / i_data_pci   host payload in;  o_ready_pci accept
//   o_valid_pci / o_data_pci   in-order result out; i_ready_pci accept
//   o_valid / o_data           flit {payload, tag, y, x} to the NoC; i_ready
//   wea / i_data_pe            returned flit (same format, no backpressure)
//   o_err                      sticky duplicate/stray-return flag, present only
//                              when SCHED_DUP_CHECK_EN is defined
module sched_noc_rob
  import sched_noc_pkg::*;
#(
  parameter int X      = 4,
  parameter int Y      = 4,
  parameter int SELF_X = 0,
  parameter int SELF_Y = 0,
  parameter int DATA_W = 256,
  parameter int TAG_W  = 5,
  localparam int XW    = clog2_min1(X),
  localparam int YW    = clog2_min1(Y),
  localparam int FW    = flit_width(XW, YW, TAG_W, DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid_pci,
  input  logic [DATA_W-1:0] i_data_pci,
  output logic              o_ready_pci,
  output logic              o_valid_pci,
  output logic [DATA_W-1:0] o_data_pci,
  input  logic              i_ready_pci,
  output logic              o_valid,
  output logic [FW-1:0]     o_data,
  input  logic              i_ready,
  input  logic              wea,
  input  logic [FW-1:0]     i_data_pe
`ifdef SCHED_DUP_CHECK_EN
  ,
  output logic              o_err
`endif
);

  localparam int DEPTH    = 1 << TAG_W;
  localparam int PW       = XW + YW;
  localparam int TAG_LSB  = flit_tag_lsb(XW, YW);
  localparam int DATA_LSB = flit_data_lsb(XW, YW, TAG_W);
  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W + 1)'(DEPTH);
  localparam logic [PW-1:0]  SELF_POS  = {YW'(SELF_Y), XW'(SELF_X)};

  // Position is packed {y, x}, matching the low bits of the flit.
  // One raster step: y is the inner index, x the outer one, wrapping at the end.
  function automatic logic [PW-1:0] raster_step(input logic [PW-1:0] p);
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    px = p[XW-1:0];
    py = p[PW-1:XW];
    if (int'(py) == Y - 1) begin
      py = '0;
      px = (int'(px) == X - 1) ? '0 : px + XW'(1);
    end else begin
      py = py + YW'(1);
    end
    return {py, px};
  endfunction

  localparam logic [PW-1:0] FIRST_POS =
      (SELF_X == 0 && SELF_Y == 0) ? raster_step('0) : '0;

  logic              o_valid_q;
  logic [FW-1:0]     o_data_q;
  logic [TAG_W-1:0]  tag_q;
  logic [PW-1:0]     pos_q;
  logic [PW-1:0]     pos_step;
  logic [PW-1:0]     pos_d;
  logic [TAG_W:0]    outstanding_q;
  logic              accept;
  logic              rel;

  // Coordinates of returned flits carry no meaning here.
  logic unused_coords;
  assign unused_coords = ^i_data_pe[PW-1:0];

  assign o_ready_pci = (!o_valid_q || i_ready) && (outstanding_q < DEPTH_CNT);
  assign accept      = i_valid_pci && o_ready_pci;
  assign o_valid     = o_valid_q;
  assign o_data      = o_data_q;

  // X*Y >= 2 guarantees at most one skip is ever needed past the own node.
  always_comb begin
    pos_step = raster_step(pos_q);
    pos_d    = (pos_step == SELF_POS) ? raster_step(pos_step) : pos_step;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid_q     <= 1'b0;
      o_data_q      <= '0;
      tag_q         <= '0;
      pos_q         <= FIRST_POS;
      outstanding_q <= '0;
    end else begin
      if (accept) begin
        o_valid_q <= 1'b1;
        o_data_q  <= {i_data_pci, tag_q, pos_q};
        tag_q     <= tag_q + TAG_W'(1);
        pos_q     <= pos_d;
      end else if (i_ready) begin
        o_valid_q <= 1'b0;
      end
      if (accept && !rel) begin
        outstanding_q <= outstanding_q + (TAG_W + 1)'(1);
      end else if (!accept && rel) begin
        outstanding_q <= outstanding_q - (TAG_W + 1)'(1);
      end
    end
  end

`ifdef SCHED_DUP_CHECK_EN
  logic dup;
  logic err_q;

  // A return with nothing outstanding is a stray; either case latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (wea && (dup || (outstanding_q == '0))) begin
      err_q <= 1'b1;
    end
  end
  assign o_err = err_q;
`endif

  sched_rob #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_rob (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wea),
    .wr_tag_i  (i_data_pe[TAG_LSB +: TAG_W]),
    .wr_data_i (i_data_pe[DATA_LSB +: DATA_W]),
    .ready_i   (i_ready_pci),
    .valid_o   (o_valid_pci),
    .data_o    (o_data_pci),
    .release_o (rel)
`ifdef SCHED_DUP_CHECK_EN
    ,
    .dup_o     (dup)
`endif
  );

endmodule

// File: tb/tb_sched_noc_rob.sv
// tb_sched_noc_rob -- bench for sched_noc_rob on a 2x2 mesh, own node (0,0),
// 16-bit payload, 2-bit tag (4 reorder slots).
module tb_sched_noc_rob;

  localparam int DW    = 16;
  localparam int TW    = 2;
  localparam int DEPTH = 4;
  localparam int FW    = DW + TW + 2;
  localparam int SX    = 0;
  localparam int SY    = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid_pci = 1'b0;
  logic [DW-1:0] i_data_pci = '0;
  logic          o_ready_pci;
  logic          o_valid_pci;
  logic [DW-1:0] o_data_pci;
  logic          i_ready_pci = 1'b0;
  logic          o_valid;
  logic [FW-1:0] o_data;
  logic          i_ready = 1'b0;
  logic          wea = 1'b0;
  logic [FW-1:0] i_data_pe = '0;
`ifdef SCHED_DUP_CHECK_EN
  logic          o_err;
`endif

  always #5 clk = ~clk;

  sched_noc_rob #(
    .X(2), .Y(2), .SELF_X(SX), .SELF_Y(SY), .DATA_W(DW), .TAG_W(TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid_pci (i_valid_pci),
    .i_data_pci  (i_data_pci),
    .o_ready_pci (o_ready_pci),
    .o_valid_pci (o_valid_pci),
    .o_data_pci  (o_data_pci),
    .i_ready_pci (i_ready_pci),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_ready     (i_ready),
    .wea         (wea),
    .i_data_pe   (i_data_pe)
`ifdef SCHED_DUP_CHECK_EN
    ,
    .o_err       (o_err)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  int            node_x[$];
  int            node_y[$];
  bit            m_ovalid;
  logic [FW-1:0] m_odata;
  int            m_tag;
  int            m_idx;
  int            m_out;
  bit            m_slot_v[DEPTH];
  logic [DW-1:0] m_slot_d[DEPTH];
  int            m_rd;
  bit            m_hvalid;
  logic [DW-1:0] m_hdata;
  bit            m_err;

  logic [FW-1:0] pending[$];   // flits handed to the NoC, not yet returned
  logic [DW-1:0] rx[$];        // results the host actually took
  logic [31:0]   exp_flit[4];
  logic [FW-1:0] f;
  int            pick;
  int            guard;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_ready();
    return (!m_ovalid || i_ready) && (m_out < DEPTH);
  endfunction

  task automatic model_reset();
    m_ovalid = 0; m_odata = '0; m_tag = 0; m_idx = 0; m_out = 0;
    m_rd = 0; m_hvalid = 0; m_hdata = '0; m_err = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_slot_v[i] = 0;
      m_slot_d[i] = '0;
    end
  endtask

  task automatic model_advance();
    bit acc, rel;
    int wtag;
    acc  = i_valid_pci && model_ready();
    rel  = m_slot_v[m_rd] && (!m_hvalid || i_ready_pci);
    wtag = int'(i_data_pe[3:2]);
    if (m_ovalid && i_ready) begin
      pending.push_back(m_odata);
      $display("noc  flit %05h", m_odata);
    end
    if (m_hvalid && i_ready_pci) $display("host result %04h", m_hdata);
    if (wea && (m_slot_v[wtag] || m_out == 0)) m_err = 1;
    if (acc) begin
      m_odata  = {i_data_pci, 2'(m_tag), 1'(node_y[m_idx]), 1'(node_x[m_idx])};
      m_ovalid = 1;
      m_tag    = (m_tag + 1) % DEPTH;
      m_idx    = (m_idx + 1) % node_x.size();
    end else if (i_ready) begin
      m_ovalid = 0;
    end
    if (rel) begin
      m_hdata        = m_slot_d[m_rd];
      m_hvalid       = 1;
      m_slot_v[m_rd] = 0;
      m_rd           = (m_rd + 1) % DEPTH;
    end else if (i_ready_pci) begin
      m_hvalid = 0;
    end
    if (wea) begin
      m_slot_d[wtag] = i_data_pe[FW-1:4];
      m_slot_v[wtag] = 1;
    end
    m_out = m_out + int'(acc) - int'(rel);
  endtask

  task automatic check_outputs();
    chk("o_valid", o_valid, m_ovalid);
    if (m_ovalid) chk("o_data", o_data, m_odata);
    chk("o_ready_pci", o_ready_pci, model_ready());
    chk("o_valid_pci", o_valid_pci, m_hvalid);
    if (m_hvalid) chk("o_data_pci", o_data_pci, m_hdata);
`ifdef SCHED_DUP_CHECK_EN
    chk("o_err", o_err, m_err);
`endif
    if (o_valid_pci && i_ready_pci) rx.push_back(o_data_pci);
  endtask

  // One clock cycle: inputs already driven; check mid-cycle, then advance model.
  task automatic step();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_return(input int tag, input logic [DW-1:0] payload);
    wea       = 1'b1;
    i_data_pe = {payload, 2'(tag), 2'($urandom_range(0, 3))};
    for (int i = pending.size() - 1; i >= 0; i--) begin
      if (int'(pending[i][3:2]) == tag) pending.delete(i);
    end
    $display("return tag %0d payload %04h", tag, payload);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, expected $finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        if (!(x == SX && y == SY)) begin
          node_x.push_back(x);
          node_y.push_back(y);
        end
    // {payload, tag, y, x} for accepts 0..3: (0,1) (1,0) (1,1) (0,1)
    exp_flit[0] = 32'h01002;
    exp_flit[1] = 32'h01015;
    exp_flit[2] = 32'h0102B;
    exp_flit[3] = 32'h0103E;
    model_reset();

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_valid_pci", o_valid_pci, 0);
    chk("rst_o_ready_pci", o_ready_pci, 1);
    check_outputs();
    @(posedge clk);
    #1 reset = 1'b0;

    // ---- destination walk and tags, then full ----
    i_ready = 1'b1;
    i_valid_pci = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data_pci = 16'h0100 + 16'(k);
      step();
      chk("walk_flit", o_data, exp_flit[k]);
    end
    i_valid_pci = 1'b0;
    #1 chk("full_ready", o_ready_pci, 0);

    // ---- out-of-order returns 2,0,3,1 ----
    i_ready_pci = 1'b1;
    set_return(2, 16'hB002); step();
    set_return(0, 16'hB000); step();
    set_return(3, 16'hB003);
    #1 chk("still_full", o_ready_pci, 0);
    chk("pci_idle", o_valid_pci, 0);
    step();
    set_return(1, 16'hB001);
    #1 chk("tag0_valid", o_valid_pci, 1);
    chk("tag0_data", o_data_pci, 16'hB000);
    chk("ready_after_release", o_ready_pci, 1);
    step();
    wea = 1'b0;
    repeat (6) step();
    chk("order_count", rx.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("order_data", (i < rx.size()) ? rx[i] : 16'hDEAD, 16'hB000 + 16'(i));
    rx.delete();

    // ---- NoC stall with o_valid high ----
    i_valid_pci = 1'b1;
    i_data_pci = 16'h0200; step();
    chk("flit_p2a", o_data, 32'h02001);
    i_data_pci = 16'h0201; step();
    chk("flit_p2b", o_data, 32'h02017);
    i_ready = 1'b0;
    i_data_pci = 16'h0222;
    for (int k = 0; k < 5; k++) begin
      #1 chk("stall_ready", o_ready_pci, 0);
      step();
      chk("stall_hold", o_data, 32'h02017);
      chk("stall_valid", o_valid, 1);
    end
    i_valid_pci = 1'b0;
    i_ready = 1'b1;
    step();

    // ---- host backpressure during release ----
    i_ready_pci = 1'b0;
    set_return(0, 16'hC000); step();
    set_return(1, 16'hC001); step();
    wea = 1'b0;
    #1 chk("hold_valid", o_valid_pci, 1);
    chk("hold_data", o_data_pci, 16'hC000);
    step(); step();
    chk("hold_data_late", o_data_pci, 16'hC000);
    i_ready_pci = 1'b1;
    step();
    chk("next_release_data", o_data_pci, 16'hC001);
    chk("next_release_valid", o_valid_pci, 1);
    step(); step();

    // ---- randomized traffic ----
    for (int c = 0; c < 800; c++) begin
      i_valid_pci = ($urandom_range(0, 2) != 0);
      i_data_pci  = 16'($urandom);
      i_ready     = ($urandom_range(0, 3) != 0);
      i_ready_pci = ($urandom_range(0, 3) != 0);
      if (pending.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, pending.size() - 1);
        f = pending[pick];
        pending.delete(pick);
        wea = 1'b1;
        i_data_pe = {f[FW-1:4] ^ 16'h5A5A, f[3:2], 2'($urandom_range(0, 3))};
      end else begin
        wea = 1'b0;
        i_data_pe = 20'($urandom);
      end
      step();
    end

    // ---- drain ----
    i_valid_pci = 1'b0;
    i_ready = 1'b1;
    i_ready_pci = 1'b1;
    guard = 0;
    while ((m_out != 0 || m_hvalid || m_ovalid || pending.size() != 0) && guard < 300) begin
      if (pending.size() > 0) begin
        f = pending.pop_front();
        wea = 1'b1;
        i_data_pe = {f[FW-1:4] ^ 16'h5A5A, f[3:2], 2'b00};
      end else begin
        wea = 1'b0;
      end
      step();
      guard++;
    end
    wea = 1'b0;
    chk("drain_within_budget", (guard < 300), 1);

    // ---- reset with two outstanding ----
    i_valid_pci = 1'b1;
    i_data_pci = 16'h03AA; step();
    i_data_pci = 16'h03BB; step();
    i_valid_pci = 1'b0;
    step();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_o_valid", o_valid, 0);
    chk("async_rst_o_data", o_data, 0);
    chk("async_rst_o_valid_pci", o_valid_pci, 0);
    chk("async_rst_o_data_pci", o_data_pci, 0);
    chk("async_rst_o_ready_pci", o_ready_pci, 1);
    model_reset();
    pending.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    i_valid_pci = 1'b1;
    i_data_pci = 16'h0300;
    step();
    i_valid_pci = 1'b0;
    chk("post_reset_flit", o_data, 32'h03002);
`ifdef SCHED_DUP_CHECK_EN
    chk("post_reset_err", o_err, 0);
    set_return(1, 16'hD001); step();
    set_return(1, 16'hD011); step();
    wea = 1'b0;
    #1 chk("dup_err", o_err, 1);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sched_noc_rob.md
SCHED_NOC_ROB -- requirements
Module: sched_noc_rob

Interface
REQ-001 Parameter: X, 4, mesh columns (>=1).
REQ-002 Parameter: Y, 4, mesh rows (>=1); X*Y SHALL be >=2.
REQ-003 Parameter: SELF_X, 0, column of the scheduler's own node, which is never a destination.
REQ-004 Parameter: SELF_Y, 0, row of the scheduler's own node.
REQ-005 Parameter: DATA_W, 256, payload width.
REQ-006 Parameter: TAG_W, 5, tag width; DEPTH = 2**TAG_W reorder slots.
REQ-007 Ports (XW=clog2(X), YW=clog2(Y), FW=DATA_W+TAG_W+YW+XW):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- i_valid_pci  in  1  host payload valid.
- i_data_pci  in  DATA_W  host payload.
- o_ready_pci  out  1  block accepts host payload.
- o_valid_pci  out  1  result valid to host.
- o_data_pci  out  DATA_W  in-order result.
- i_ready_pci  in  1  host accepts result.
- o_valid  out  1  flit valid to NoC.
- o_data  out  FW  flit {payload, tag, y, x}, x at LSB.
- i_ready  in  1  NoC accepts flit.
- wea  in  1  returned flit valid (no backpressure).
- i_data_pe  in  FW  returned flit, same format.
REQ-008 With SCHED_DUP_CHECK_EN defined: o_err  out  1  sticky duplicate/stray-return flag.

Function
REQ-009 Host accept SHALL occur when i_valid_pci && o_ready_pci; o_ready_pci = (!o_valid || i_ready) && (outstanding < DEPTH), combinational.
REQ-010 On accept, o_data/o_valid SHALL register next cycle (1-cycle latency); o_valid and o_data SHALL hold stable until i_ready.
REQ-011 Destination SHALL walk raster order, y inner, x outer, from (0,0), skipping (SELF_X,SELF_Y), wrapping after (X-1,Y-1) to the first non-self node; advances only on accept.
REQ-012 Tag SHALL be a TAG_W counter, incremented mod DEPTH per accept, starting at 0.
REQ-013 outstanding (TAG_W+1 bits) SHALL +1 on accept, -1 on host release, unchanged on both in one cycle.
REQ-014 On wea, payload SHALL be written to slot[tag of i_data_pe] and its valid bit set; coordinates are ignored.
REQ-015 Release: when slot[rd_ptr] is valid and (!o_valid_pci || i_ready_pci), o_data_pci SHALL load that slot next cycle, o_valid_pci set, valid bit cleared, rd_ptr incremented mod DEPTH.
REQ-016 o_valid_pci/o_data_pci SHALL hold until i_ready_pci; o_valid_pci drops after handshake if no next slot is ready.
REQ-017 Returns SHALL be released strictly in tag order regardless of arrival order; sustained throughput 1 flit/cycle each direction.
REQ-018 wea to slot rd_ptr in the same cycle that slot is released: release uses old data, the write sets valid (set wins over clear).
REQ-019 Without SCHED_DUP_CHECK_EN, a wea to an already-valid slot SHALL overwrite silently.

Reset
REQ-020 reset SHALL asynchronously clear o_valid, o_valid_pci, o_data, o_data_pci, tag, rd_ptr, outstanding, all slot valid bits, and o_err, and set destination to the first non-self node.
REQ-021 Flits in flight at reset SHALL be dropped; returns of pre-reset tags are not protected.

Configuration
REQ-022 Macro SCHED_DUP_CHECK_EN: defined -> o_err set on wea to a valid slot or when outstanding==0; cleared only by reset; undefined -> port and logic absent.

Structure
REQ-023 Package sched_noc_pkg SHALL hold flit field offset functions, clog2 helper, and the flit struct typedef.
REQ-024 Sub-module sched_rob SHALL implement slot storage, valid bits, rd_ptr and release handshake; the top holds ingress, destination walk and counters.

Verification
REQ-025 X=2,Y=2,self(0,0): 4 accepts -> flits to (0,1),(1,0),(1,1),(0,1), tags 0,1,2,3.
REQ-026 i_ready low 5 cycles with o_valid=1 -> o_data stable, o_ready_pci=0, no extra accept.
REQ-027 TAG_W=2: 4 accepts, no returns -> o_ready_pci=0; one return and release -> o_ready_pci=1.
REQ-028 Returns tags 2,0,3,1 -> host receives payloads for tags 0,1,2,3 in order; tag 0 released the cycle after its return.
REQ-029 i_ready_pci low during release -> o_data_pci held; raising it releases the next slot in the following cycle.
REQ-030 reset mid-stream (2 outstanding) -> all outputs 0, next accept uses tag 0 to (0,1); with SCHED_DUP_CHECK_EN, second wea to tag 1 -> o_err=1.
